// File: rtl/fb_decimate_writer_pkg.sv
// Shared frame-buffer geometry for the decimating writer and the display-side reader.
// Both ends import these so the row*COLS+col layout stays in agreement.
package fb_decimate_writer_pkg;

    localparam int PIX_W      = 8;
    localparam int H_ACT      = 640;
    localparam int V_ACT      = 480;
    localparam int SCALE_LOG2 = 3;
    localparam int COLS       = H_ACT >> SCALE_LOG2;
    localparam int ROWS       = V_ACT >> SCALE_LOG2;
    localparam int ADDR_W     = 13;
    localparam int ACC_W      = PIX_W + 2 * SCALE_LOG2;

endpackage

// File: rtl/fb_acc_line.sv
// One line of block accumulators: combinational read, synchronous write,
// so a read-modify-write of one entry completes in a single cycle.
module fb_acc_line
    import fb_decimate_writer_pkg::*;
#(
    parameter int DEPTH = COLS,
    parameter int WIDTH = ACC_W,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [WIDTH-1:0] wr_data_i
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rd_data_o = mem_q[rd_idx_i];

    // No reset: every entry is overwritten at the first pixel of each block.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fb_decimate_writer.sv
// Box-averages each 2^SCALE_LOG2 square of a raster pixel stream into one pixel
// and writes it to the frame buffer at row*COLS+col, one cycle after the block's last pixel.
module fb_decimate_writer
    import fb_decimate_writer_pkg::*;
#(
    parameter int PIX_W      = fb_decimate_writer_pkg::PIX_W,
    parameter int H_ACT      = fb_decimate_writer_pkg::H_ACT,
    parameter int V_ACT      = fb_decimate_writer_pkg::V_ACT,
    parameter int SCALE_LOG2 = fb_decimate_writer_pkg::SCALE_LOG2,
    parameter int ADDR_W     = fb_decimate_writer_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              frame_done,
    output logic              resync_err
);

    localparam int N_COLS = H_ACT >> SCALE_LOG2;
    localparam int N_ROWS = V_ACT >> SCALE_LOG2;
    localparam int SUM_W  = PIX_W + 2 * SCALE_LOG2;
    localparam int X_W    = $clog2(H_ACT);
    localparam int Y_W    = $clog2(V_ACT);
    localparam int COL_W  = $clog2(N_COLS);

    localparam logic [X_W-1:0]        X_LAST    = X_W'(H_ACT - 1);
    localparam logic [Y_W-1:0]        Y_LAST    = Y_W'(V_ACT - 1);
    localparam logic [SCALE_LOG2-1:0] SUB_LAST  = '1;
    localparam logic [ADDR_W-1:0]     BAND_STEP = ADDR_W'(N_COLS);
    localparam logic [ADDR_W-1:0]     ADDR_LAST = ADDR_W'(N_COLS * N_ROWS - 1);

    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic              resync_err_q, resync_err_d;

    logic [X_W-1:0]    cur_x;
    logic [Y_W-1:0]    cur_y;
    logic [ADDR_W-1:0] cur_base;
    logic [ADDR_W-1:0] blk_addr;
    logic [COL_W-1:0]  col;
    logic              block_start;
    logic              block_end;
    logic [SUM_W-1:0]  acc_rd;
    logic [SUM_W-1:0]  sum;

    fb_acc_line #(
        .DEPTH (N_COLS),
        .WIDTH (SUM_W),
        .IDX_W (COL_W)
    ) u_acc_line (
        .clk_i     (clk),
        .rd_idx_i  (col),
        .rd_data_o (acc_rd),
        .wr_en_i   (pix_valid),
        .wr_idx_i  (col),
        .wr_data_i (sum)
    );

    // A start-of-frame pixel is forced to (0,0) and row band 0 regardless of counter state.
    always_comb begin
        cur_x       = pix_sof ? '0 : x_q;
        cur_y       = pix_sof ? '0 : y_q;
        cur_base    = pix_sof ? '0 : row_base_q;
        col         = COL_W'(cur_x >> SCALE_LOG2);
        blk_addr    = cur_base + ADDR_W'(col);
        block_start = (cur_x[SCALE_LOG2-1:0] == '0) && (cur_y[SCALE_LOG2-1:0] == '0);
        block_end   = pix_valid && (cur_x[SCALE_LOG2-1:0] == SUB_LAST)
                                && (cur_y[SCALE_LOG2-1:0] == SUB_LAST);
        sum         = block_start ? SUM_W'(pix_data) : acc_rd + SUM_W'(pix_data);
    end

    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        row_base_d   = row_base_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        resync_err_d = 1'b0;

        if (pix_valid) begin
            resync_err_d = pix_sof && ((x_q != '0) || (y_q != '0));

            // Row base tracks (y>>SCALE_LOG2)*N_COLS without a multiplier.
            if (cur_x == X_LAST) begin
                x_d = '0;
                if (cur_y == Y_LAST) begin
                    y_d        = '0;
                    row_base_d = '0;
                end else begin
                    y_d        = cur_y + Y_W'(1);
                    row_base_d = (cur_y[SCALE_LOG2-1:0] == SUB_LAST) ? cur_base + BAND_STEP
                                                                     : cur_base;
                end
            end else begin
                x_d        = cur_x + X_W'(1);
                y_d        = cur_y;
                row_base_d = cur_base;
            end

            if (block_end) begin
                wr_en_d      = 1'b1;
                wr_addr_d    = blk_addr;
                wr_data_d    = sum[SUM_W-1 -: PIX_W];
                frame_done_d = (blk_addr == ADDR_LAST);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            row_base_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            resync_err_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            row_base_q   <= row_base_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            resync_err_q <= resync_err_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign resync_err = resync_err_q;

endmodule

// File: tb/tb_fb_decimate_writer.sv
// Directed bench for fb_decimate_writer on a 128x32 raster (16x4 blocks);
// expected writes are queued as pixels are driven and popped as the DUT writes.
module tb_fb_decimate_writer;

    localparam int H    = 128;
    localparam int V    = 32;
    localparam int S    = 3;
    localparam int AW   = 13;
    localparam int NC   = H >> S;
    localparam int NR   = V >> S;
    localparam int NBLK = NC * NR;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_valid;
    logic          pix_sof;
    logic [7:0]    pix_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          frame_done;
    logic          resync_err;

    typedef struct {
        int addr;
        int data;
        bit fd;
    } exp_t;

    exp_t expQ[$];
    int   tests = 0;
    int   failed = 0;
    int   mx = 0;
    int   my = 0;
    int   msum[NC];
    int   cyc = 0;
    int   lastWr = 0;
    bit   seenWr = 1'b0;
    int   writeCount = 0;
    int   fdCount = 0;
    int   resyncCount = 0;
    int   spurious = 0;
    int   lastData[NBLK];

    always #5 clk = ~clk;

    fb_decimate_writer #(
        .PIX_W      (8),
        .H_ACT      (H),
        .V_ACT      (V),
        .SCALE_LOG2 (S),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_data   (pix_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .resync_err (resync_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: block sums and expected writes straight from the raster position.
    task automatic modelPixel(input logic s, input logic [7:0] d);
        int c;
        if (s) begin
            mx = 0;
            my = 0;
        end
        c = mx / 8;
        if ((mx % 8 == 0) && (my % 8 == 0)) msum[c] = int'(d);
        else                                msum[c] += int'(d);
        if ((mx % 8 == 7) && (my % 8 == 7))
            expQ.push_back('{addr: (my / 8) * NC + c, data: (msum[c] / 64) & 255,
                             fd: (mx == H - 1) && (my == V - 1)});
        mx++;
        if (mx == H) begin
            mx = 0;
            my++;
            if (my == V) my = 0;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d);
        @(posedge clk);
        #1;
        pix_valid = v;
        pix_sof   = s;
        pix_data  = d;
        if (v) modelPixel(s, d);
    endtask

    task automatic sendFrame(input logic [7:0] cv, input bit useX, input bit sof, input int idlePct);
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                while ($urandom_range(0, 99) < idlePct) applyStimulus(1'b0, 1'b0, 8'($urandom));
                applyStimulus(1'b1, sof && (x == 0) && (y == 0), useX ? 8'(x) : cv);
            end
        end
    endtask

    task automatic endTest(input string name, input int expW, input int expFd, input int expRs);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput({name, "_writes"}, writeCount, expW);
        checkOutput({name, "_frame_done"}, fdCount, expFd);
        checkOutput({name, "_resync"}, resyncCount, expRs);
        checkOutput({name, "_spurious"}, spurious, 0);
        checkOutput({name, "_pending"}, expQ.size(), 0);
        writeCount  = 0;
        fdCount     = 0;
        resyncCount = 0;
        spurious    = 0;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (resync_err) resyncCount++;
            if (frame_done) fdCount++;
            if (wr_en) begin
                writeCount++;
                if (seenWr) checkOutput("wr_gap_ge8", 32'((cyc - lastWr) >= 8), 1);
                lastWr = cyc;
                seenWr = 1'b1;
                if (int'(wr_addr) < NBLK) lastData[int'(wr_addr)] = int'(wr_data);
                if (expQ.size() == 0) begin
                    spurious++;
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wr_addr", wr_addr, e.addr);
                    checkOutput("wr_data", wr_data, e.data);
                    checkOutput("wr_frame_done", frame_done, e.fd);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_resync_err", resync_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] constant 0x40 frame");
        sendFrame(8'h40, 1'b0, 1'b1, 0);
        endTest("const40", NBLK, 1, 0);
        checkOutput("const40_first", lastData[0], 8'h40);
        checkOutput("const40_last", lastData[NBLK - 1], 8'h40);
        checkOutput("const40_addr_hold", wr_addr, NBLK - 1);
        checkOutput("const40_data_hold", wr_data, 8'h40);

        $display("[TB] x ramp frame");
        sendFrame(8'h00, 1'b1, 1'b1, 0);
        endTest("xramp", NBLK, 1, 0);
        checkOutput("xramp_col0", lastData[0], 8'h03);
        checkOutput("xramp_col1", lastData[1], 8'h0B);
        checkOutput("xramp_col15", lastData[NC - 1], 8'h7B);

        $display("[TB] 0xFF frame with idle gaps");
        sendFrame(8'hFF, 1'b0, 1'b1, 30);
        endTest("gaps", NBLK, 1, 0);
        checkOutput("gaps_last", lastData[NBLK - 1], 8'hFF);

        $display("[TB] sof at (100,17)");
        for (int i = 0; i < 17 * H + 100; i++) applyStimulus(1'b1, i == 0, 8'h10);
        sendFrame(8'h10, 1'b0, 1'b1, 0);
        endTest("sof_resync", 2 * NC + NBLK, 1, 1);
        checkOutput("sof_resync_addr0", lastData[0], 8'h10);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 20 * H; i++) applyStimulus(1'b1, i == 0, 8'h80);
        @(posedge clk);
        #3;
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        #1;
        checkOutput("midrst_wr_en", wr_en, 0);
        checkOutput("midrst_wr_addr", wr_addr, 0);
        checkOutput("midrst_wr_data", wr_data, 0);
        checkOutput("midrst_pending", expQ.size(), 0);
        mx = 0;
        my = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("midrst_hold_addr", wr_addr, 0);
        rst = 1'b0;
        endTest("pre_reset", 2 * NC, 0, 0);
        sendFrame(8'h80, 1'b0, 1'b0, 0);
        endTest("post_reset", NBLK, 1, 0);
        checkOutput("post_reset_addr0", lastData[0], 8'h80);

        $display("[TB] two frames, sof on first only");
        sendFrame(8'h33, 1'b0, 1'b1, 0);
        endTest("frame_a", NBLK, 1, 0);
        sendFrame(8'h55, 1'b0, 1'b0, 0);
        endTest("frame_b", NBLK, 1, 0);
        checkOutput("frame_b_first", lastData[0], 8'h55);
        checkOutput("frame_b_last", lastData[NBLK - 1], 8'h55);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
